forwarding_hazard_unit: RTL
===========================

Name: forwarding_hazard_unit

Overview:
- Sequential forwarding and hazard controller for the 5-stage MIPS pipeline.
- Shadows destination-register info of in-flight instructions in EX, MEM and WB.
- Produces registered 2-bit selectors for the two EX-stage ALU-operand 3:1 multiplexers: 00 = register file, 01 = MEM/WB result, 10 = EX/MEM result.
- Generates load-use stalls and bubbles for PC, IF/ID and ID/EX.

Parameters:
- REG_ADDR_W, 5, register address width; register 0 is hardwired zero and never forwarded.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- hold_in  input  1  global freeze (e.g. memory busy); all state holds.
- flush_in  input  1  kill the ID-stage instruction (taken branch/jump).
- id_rs  input  REG_ADDR_W  ID-stage source register A.
- id_rt  input  REG_ADDR_W  ID-stage source register B.
- id_rs_used  input  1  ID instruction reads rs.
- id_rt_used  input  1  ID instruction reads rt.
- id_wr_en  input  1  ID instruction writes a register.
- id_wr_addr  input  REG_ADDR_W  ID instruction destination register.
- id_is_load  input  1  ID instruction is lw.
- fwd_a_sel  output  2  EX operand-A mux selector (registered).
- fwd_b_sel  output  2  EX operand-B mux selector (registered).
- pc_write_en  output  1  PC may update (combinational).
- ifid_write_en  output  1  IF/ID may update (combinational).
- idex_bubble  output  1  ID/EX loads a NOP this edge (combinational).

Behaviour:
- State: three stage entries EX, MEM, WB, each holding {valid, wr_en, wr_addr, is_load}, plus fwd_a_sel and fwd_b_sel registers.
- Reset (clk edge with reset=0): all valid bits 0, fwd_a_sel=fwd_b_sel=2'b00. Outputs after reset: pc_write_en=1, ifid_write_en=1, idex_bubble=0.
- Writer hit X(s): X.valid & X.wr_en & X.wr_addr==s & s!=0.
- Load-use hazard: EX.valid & EX.is_load & EX.wr_en & EX.wr_addr!=0 & ((id_rs_used & EX.wr_addr==id_rs) | (id_rt_used & EX.wr_addr==id_rt)) & !flush_in.
- Combinational outputs:
  - stall = load-use hazard & !hold_in.
  - pc_write_en = ifid_write_en = !(stall | hold_in).
  - idex_bubble = stall | (flush_in & !hold_in).
- Selector computation, done in ID and registered so it is valid when the instruction sits in EX. For operand A (operand B identical, using rt and id_rt_used):
  - If id_rs_used and the current EX entry hits id_rs, next sel = 10; that instruction is in EX/MEM next cycle.
  - Else if the current MEM entry hits id_rs, next sel = 01; that instruction is in MEM/WB next cycle.
  - Else 00. EX has priority over MEM (youngest producer wins).
- A WB-stage producer needs no forward; the register file is write-through.
- Edge update when hold_in=0:
  - WB <= MEM; MEM <= EX.
  - If idex_bubble: EX.valid <= 0 and both selectors <= 00.
  - Otherwise EX <= {1, id_wr_en, id_wr_addr, id_is_load} and selectors <= computed values.
- hold_in=1: every register holds, flush_in is ignored; upstream keeps flush asserted until hold drops.
- flush_in together with a load-use hazard: flush wins, no stall, bubble inserted.
- Load-use latency: exactly 1 stall cycle. The next cycle the load is in MEM, and the re-evaluated ID instruction gets sel=01.
- Writes to register 0 never match; sel stays 00.
- Mid-operation reset discards all in-flight entries in the same edge.

Optional Feature:
- Macro FWD_STATS_EN.
- When defined, adds outputs fwd_count[31:0] and stall_count[31:0]:
  - Both reset to 0.
  - fwd_count increments on each non-hold edge where either newly loaded selector is nonzero (+1 per edge, not per operand).
  - stall_count increments on each edge with stall=1.
  - Both wrap at 2^32.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: reset=0 for 2 cycles -> fwd_a_sel=fwd_b_sel=00, pc_write_en=1, ifid_write_en=1, idex_bubble=0.
- EX-to-EX forward: add $8 then add $9,$8,$10 back-to-back -> fwd_a_sel=10 while second add is in EX, fwd_b_sel=00.
- MEM forward and priority:
  - add $8; nop; sub using $8 -> fwd_a_sel=01.
  - add $8; add $8; sub using $8 in rt -> fwd_b_sel=10 (youngest producer wins).
- Load-use: lw $8 then add $9,$8,$8 -> one cycle with pc_write_en=0, ifid_write_en=0, idex_bubble=1; then add enters EX with fwd_a_sel=fwd_b_sel=01.
- Register 0 and flush:
  - Write to $0 followed by a use of $0 -> selectors 00.
  - lw $8 with flush_in=1 on the dependent ID instruction -> no stall, idex_bubble=1.
- Hold and reset:
  - hold_in=1 for 3 cycles mid-sequence -> selectors and stage state unchanged, pc_write_en=0.
  - Reset asserted during a pending forward -> selectors 00 next edge.

Source files
------------

// File: rtl/forwarding_hazard_unit.sv
// EX-stage operand forwarding selectors and load-use stall/bubble control for a 5-stage MIPS pipeline.
// Optional FWD_STATS_EN adds forward/stall event counters.
module fwd_operand_sel #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic                  used_i,
  input  logic                  ex_wr_i,
  input  logic [REG_ADDR_W-1:0] ex_addr_i,
  input  logic                  mem_wr_i,
  input  logic [REG_ADDR_W-1:0] mem_addr_i,
  output logic [1:0]            sel_o
);
  logic ex_hit, mem_hit;

  assign ex_hit  = used_i & ex_wr_i  & (ex_addr_i  == src_i) & (src_i != '0);
  assign mem_hit = used_i & mem_wr_i & (mem_addr_i == src_i) & (src_i != '0);

  // Youngest producer wins: EX result beats the older MEM result.
  always_comb begin
    sel_o = 2'b00;
    if (ex_hit)       sel_o = 2'b10;
    else if (mem_hit) sel_o = 2'b01;
  end
endmodule

module forwarding_hazard_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold_in,
  input  logic                  flush_in,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_wr_addr,
  input  logic                  id_is_load,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic                  idex_bubble
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]           fwd_count,
  output logic [31:0]           stall_count
`endif
);
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic                  is_load;
  } ex_ent_t;

  // The WB producer is covered by the write-through register file, so only
  // EX and MEM shadows influence anything; MEM no longer needs is_load.
  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
  } mem_ent_t;

  ex_ent_t  ex_q, ex_d;
  mem_ent_t mem_q;

  logic [NUM_OPS-1:0][REG_ADDR_W-1:0] src;
  logic [NUM_OPS-1:0]                 used;
  logic [NUM_OPS-1:0][1:0]            sel_d, sel_q;

  logic load_use, stall;

  assign src  = {id_rt, id_rs};
  assign used = {id_rt_used, id_rs_used};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    fwd_operand_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
      .src_i      (src[g]),
      .used_i     (used[g]),
      .ex_wr_i    (ex_q.valid & ex_q.wr_en),
      .ex_addr_i  (ex_q.wr_addr),
      .mem_wr_i   (mem_q.valid & mem_q.wr_en),
      .mem_addr_i (mem_q.wr_addr),
      .sel_o      (sel_d[g])
    );
  end

  // A taken branch kills the consumer, so its dependency cannot stall.
  assign load_use = ex_q.valid & ex_q.is_load & ex_q.wr_en & (ex_q.wr_addr != '0) &
                    ((id_rs_used & (ex_q.wr_addr == id_rs)) |
                     (id_rt_used & (ex_q.wr_addr == id_rt))) & ~flush_in;
  assign stall         = load_use & ~hold_in;
  assign pc_write_en   = ~(stall | hold_in);
  assign ifid_write_en = ~(stall | hold_in);
  assign idex_bubble   = stall | (flush_in & ~hold_in);

  assign ex_d = '{valid: 1'b1, wr_en: id_wr_en, wr_addr: id_wr_addr, is_load: id_is_load};

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      sel_q <= '0;
    end else if (!hold_in) begin
      mem_q <= '{valid: ex_q.valid, wr_en: ex_q.wr_en, wr_addr: ex_q.wr_addr};
      if (idex_bubble) begin
        ex_q  <= '0;
        sel_q <= '0;
      end else begin
        ex_q  <= ex_d;
        sel_q <= sel_d;
      end
    end
  end

  assign fwd_a_sel = sel_q[0];
  assign fwd_b_sel = sel_q[1];

`ifdef FWD_STATS_EN
  logic [31:0] fwd_count_q, stall_count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fwd_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      if (!hold_in && !idex_bubble && (|sel_d)) fwd_count_q <= fwd_count_q + 32'd1;
      if (stall) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign fwd_count   = fwd_count_q;
  assign stall_count = stall_count_q;
`endif
endmodule
